// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
//   IF/ID pipeline register for the MIPS core. It has a two-entry skid buffer
//   (main + skid) and a valid/ready handshake on both sides. in_ready depends
//   only on registered state, so there is no combinational path from ID ready
//   back to IF ready, and fetch can still run at full rate.
//
//   Occupancy is encoded directly by the two valid flags:
//     EMPTY : main_valid=0, skid_valid=0
//     ONE   : main_valid=1, skid_valid=0
//     FULL  : main_valid=1, skid_valid=1
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             kills all held and incoming beats (branch/jump taken)
//   in_valid/in_ready fetch-side handshake; in_ready = !skid_valid, 0 in reset
//   in_instr, in_pc4  fetched instruction and its PC+4
//   out_valid/out_ready ID-side handshake; out_valid = main_valid
//   out_instr, out_pc4  held beat, forced to 0 (NOP) when !out_valid
//   opcode, rs, rt, rd, shamt, funct, imm16  fields decoded from out_instr
//
// Configuration
//   IFID_PERF_CNT_EN  when defined, adds the free-running wrap-around counters
//                     stall_cnt (out_valid & !out_ready cycles) and
//                     flush_cnt (flush cycles while any beat is held).
// ---------------------------------------------------------------------------
module if_id_skid_reg #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm16
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    logic               main_valid;
    logic               skid_valid;
    logic [INSTR_W-1:0] main_instr;
    logic [PC_W-1:0]    main_pc4;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc4;

    logic accept;
    logic drain;

    assign in_ready  = !skid_valid && !reset;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    // Valid flags: reset beats flush, and flush beats any accept/drain.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_valid <= 1'b1;
            end
        end else if (!skid_valid) begin
            if (accept && !drain) begin
                skid_valid <= 1'b1;
            end else if (drain && !accept) begin
                main_valid <= 1'b0;
            end
        end else if (drain) begin
            skid_valid <= 1'b0;
        end
    end

    // Data registers load only on their own enable, so an undriven in_instr
    // while in_valid=0 never reaches the outputs. Flush needs no data clear
    // because the outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_instr <= '0;
            main_pc4   <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
        end else if (!flush) begin
            if (skid_valid) begin
                if (drain) begin
                    main_instr <= skid_instr;
                    main_pc4   <= skid_pc4;
                end
            end else if (accept) begin
                if (main_valid && !drain) begin
                    skid_instr <= in_instr;
                    skid_pc4   <= in_pc4;
                end else begin
                    main_instr <= in_instr;
                    main_pc4   <= in_pc4;
                end
            end
        end
    end

    // ID sees a NOP (all zero) whenever no beat is presented.
    always_comb begin
        out_instr = '0;
        out_pc4   = '0;
        if (main_valid) begin
            out_instr = main_instr;
            out_pc4   = main_pc4;
        end
    end

    assign opcode = out_instr[31:26];
    assign rs     = out_instr[25:21];
    assign rt     = out_instr[20:16];
    assign rd     = out_instr[15:11];
    assign shamt  = out_instr[10:6];
    assign funct  = out_instr[5:0];
    assign imm16  = out_instr[15:0];

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (main_valid || skid_valid)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: the stimulus process pushes each
// accepted beat into a queue, the monitor pops and compares on every drain.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc4, out_instr, out_pc4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    if_id_skid_reg #(.INSTR_W(32), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc4(in_pc4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc4(out_pc4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm16(imm16)
`ifdef IFID_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every drained beat against the head of the queue,
    // and require NOP outputs whenever nothing is presented.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got instr 0x%0h expected none", out_instr);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("drain_instr", {32'd0, out_instr}, {32'd0, b.instr});
                chk("drain_pc4", {32'd0, out_pc4}, {32'd0, b.pc4});
                chk("drain_fields",
                    {opcode, rs, rt, rd, shamt, funct, imm16},
                    {b.instr[31:26], b.instr[25:21], b.instr[20:16], b.instr[15:11],
                     b.instr[10:6], b.instr[5:0], b.instr[15:0]});
            end
        end
        if (!out_valid) begin
            chk("nop_outputs",
                {out_instr, out_pc4} | {28'd0, opcode, rs, rt, rd, shamt, funct, imm16},
                64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat for one cycle; push it when the handshake will complete.
    task automatic offer(input logic [31:0] instr, input logic [31:0] pc4);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc4   = pc4;
        @(negedge clk);
        if (in_ready && !flush && !reset) exp_q.push_back('{instr, pc4});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc4 = '0;

        // 1: reset held two cycles
        repeat (2) begin
            @(negedge clk);
            chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
            chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
`ifdef IFID_PERF_CNT_EN
        chk("reset_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        chk("reset_flush_cnt", {32'd0, flush_cnt}, 64'd0);
`endif
        step();

        // 2: addi $t0,$0,-7 decodes the cycle after accept
        out_ready = 1'b1;
        offer(32'h2008FFF9, 32'h4);
        in_valid = 1'b0;
        @(negedge clk);
        chk("addi_valid", {63'd0, out_valid}, 64'd1);
        chk("addi_opcode", {58'd0, opcode}, 64'h08);
        chk("addi_rs", {59'd0, rs}, 64'd0);
        chk("addi_rt", {59'd0, rt}, 64'd8);
        chk("addi_imm16", {48'd0, imm16}, 64'hFFF9);
        step();

        // 3: fill to FULL with ID stalled, then release
        out_ready = 1'b0;
        offer(32'h11, 32'h100);
        offer(32'h22, 32'h104);
        in_valid = 1'b1; in_instr = 32'h33; in_pc4 = 32'h108;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", {63'd0, in_ready}, 64'd0);
            chk("full_head", {32'd0, out_instr}, 64'h11);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {63'd0, in_ready}, 64'd0);
        chk("order_0", {32'd0, out_instr}, 64'h11);
        step();
        @(negedge clk);
        chk("release_in_ready2", {63'd0, in_ready}, 64'd1);
        chk("order_1", {32'd0, out_instr}, 64'h22);
        if (in_ready) exp_q.push_back('{32'h33, 32'h108});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("order_2", {32'd0, out_instr}, 64'h33);
        step();
        @(negedge clk);
        chk("drained_out_valid", {63'd0, out_valid}, 64'd0);
        step();

        // 4: flush while FULL with an incoming beat
        out_ready = 1'b0;
        offer(32'hA1, 32'h200);
        offer(32'hA2, 32'h204);
        in_valid = 1'b1; in_instr = 32'hA3; in_pc4 = 32'h208; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step();

        // 4b: flush in ONE with a same-cycle drain; drained beat is consumed
        offer(32'hB1, 32'h300);
        out_ready = 1'b1; flush = 1'b1;
        in_valid = 1'b1; in_instr = 32'hB2; in_pc4 = 32'h304;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drain_q", {32'd0, 32'(exp_q.size())}, 64'd0);
        exp_q.delete();
        offer(32'hC1, 32'h400);
        in_valid = 1'b0;
        @(negedge clk);
        chk("after_flush_beat", {32'd0, out_instr}, 64'hC1);
        step();

        // 5: flush and reset together
        out_ready = 1'b0;
        offer(32'hD1, 32'h500);
        in_valid = 1'b0;
        reset = 1'b1; flush = 1'b1;
        step();
        exp_q.delete();
        @(negedge clk);
        chk("rst_flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flush_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        reset = 1'b0; flush = 1'b0;
        @(negedge clk);
`ifdef IFID_PERF_CNT_EN
        chk("rst_flush_cnt", {32'd0, flush_cnt}, 64'd0);
`endif
        chk("rst_flush_ready", {63'd0, in_ready}, 64'd1);
        step();

        // 6: five stalled cycles, then a counted and an uncounted flush
        out_ready = 1'b0;
        offer(32'hE1, 32'h600);
        in_valid = 1'b0;
        repeat (4) step();
        @(posedge clk);
        #1;
        @(negedge clk);
`ifdef IFID_PERF_CNT_EN
        chk("stall_cnt", {32'd0, stall_cnt}, 64'd5);
`endif
        chk("stall_head", {32'd0, out_instr}, 64'hE1);
        flush = 1'b1;
        step();
        exp_q.delete();
        step();
        flush = 1'b0;
        @(negedge clk);
`ifdef IFID_PERF_CNT_EN
        chk("flush_cnt", {32'd0, flush_cnt}, 64'd1);
`endif
        chk("final_out_valid", {63'd0, out_valid}, 64'd0);
        chk("final_queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
